ifetch_unit: RTL
================

# ifetch_unit

Multi-cycle instruction fetch sequencer sitting directly downstream of the program-counter register. Samples the current PC, issues a request/acknowledge read to instruction memory, presents the returned word to decode with a valid/ready handshake, and drives `pc_en` so the PC register only advances once decode has accepted the instruction. Also handles redirect flushes, misaligned-PC faults and memory timeouts.

## Interface
- `TIMEOUT`, 16: max cycles in WAIT/DRAIN without `imem_ack` before a bus error (legal range 2..255).
- `NOP_WORD`, 32'h0000_0000: value driven on `inst_out` when no valid instruction is held.

- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `PC`  in  32  current PC from the PC register.
- `pc_en`  out  1  combinational; load enable for the PC register this edge.
- `flush`  in  1  redirect: the PC mux selects a new target this cycle.
- `imem_req`  out  1  registered memory read request.
- `imem_addr`  out  32  registered; word address being fetched.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word from memory.
- `inst_out`  out  32  registered instruction to decode.
- `inst_pc`  out  32  registered address of `inst_out`.
- `inst_valid`  out  1  registered; `inst_out` is valid.
- `dec_ready`  in  1  decode accepts `inst_out` this cycle.
- `fault`  out  1  sticky misaligned-PC fault; cleared only by `RST`.
- `bus_err`  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, WAIT, HOLD, DRAIN, FAULT. 8-bit wait counter `wcnt`.
- IDLE: if `flush`, assert `pc_en` and stay in IDLE. Else if `PC[1:0] != 0`, go to FAULT. Else latch `imem_addr <= PC`, `imem_req <= 1`, `wcnt <= 0`, and go to WAIT.
- WAIT: `imem_req` is held at 1.
  - On `imem_ack`: `inst_out <= imem_rdata`, `inst_pc <= imem_addr`, `inst_valid <= 1`, `imem_req <= 0`, go to HOLD.
  - On `flush` without ack: assert `pc_en`, go to DRAIN.
  - On `flush` with ack: assert `pc_en`, discard the data, `imem_req <= 0`, go to IDLE.
  - If neither and `wcnt == TIMEOUT-1`: pulse `bus_err`, `imem_req <= 0`, go to FAULT. Otherwise `wcnt++`.
- HOLD: `inst_valid = 1`.
  - `dec_ready` with no `flush`: `pc_en = 1`, `inst_valid <= 0`, `inst_out <= NOP_WORD`, go to IDLE.
  - `flush` (has priority over `dec_ready`): `pc_en = 1`, `inst_valid <= 0`, go to IDLE. The instruction is dropped.
- DRAIN: `imem_req` is held at 1 until `imem_ack`; the ack data is discarded; then `imem_req <= 0` and go to IDLE. `flush` is ignored and `pc_en` stays 0. On timeout, pulse `bus_err` and go to IDLE (no fault).
- FAULT: `fault = 1`, `imem_req = 0`, `inst_valid = 0`, `pc_en = 0`. Terminal until `RST`.
- `pc_en` is asserted only in the cases listed above, never in any other state.

## Timing
- Reset values: state IDLE, `imem_req` 0, `imem_addr` 0, `inst_out` `NOP_WORD`, `inst_pc` 0, `inst_valid` 0, `fault` 0, `bus_err` 0, `wcnt` 0.
- `RST` overrides every state, including mid-WAIT. `imem_req` drops on the reset edge, and a late `imem_ack` in IDLE is ignored.
- Best case is 3 cycles per instruction: IDLE, WAIT with ack, HOLD with `dec_ready`.
- `inst_valid` rises on the edge after `imem_ack`.
- `pc_en` is high during the HOLD cycle where `dec_ready` is sampled, so the PC register loads on that same edge. The next IDLE then sees the new PC.
- `imem_addr` is stable for the whole request.
- `bus_err` fires in the cycle where `wcnt == TIMEOUT-1` with no ack, i.e. the TIMEOUT-th WAIT cycle.

## Test plan
- **Basic fetch.** Reset, PC=0x0000_0040, ack on the 1st WAIT cycle with rdata 0x2008_0005, `dec_ready`=1 → `imem_addr`=0x40. `inst_out`=0x2008_0005, `inst_pc`=0x40, `inst_valid` for 1 cycle, then `pc_en` pulse; 3 cycles total.
- **Decode backpressure.** `dec_ready`=0 for 4 cycles → `inst_valid` and `inst_out` held, `pc_en`=0 throughout. `pc_en`=1 exactly in the cycle `dec_ready` rises.
- **Flush in WAIT.** Flush on the 2nd WAIT cycle, ack 3 cycles later with 0xDEAD_BEEF → `pc_en` pulses once and `inst_valid` never rises. Back in IDLE, the fetch uses the redirected PC.
- **Misaligned PC.** PC=0x0000_0042 → no `imem_req`. `fault`=1 from the next cycle and stays 1 until `RST`.
- **Timeout.** `TIMEOUT`=4, no ack → `bus_err` pulse on the 4th WAIT cycle, `imem_req` drops, and `fault`=1.
- **Reset mid-WAIT.** `RST` on the 2nd WAIT cycle, ack arrives on the next cycle → all outputs at reset values and the ack is ignored.

Source files
------------

// File: rtl/ifetch_unit.sv
// Multi-cycle instruction fetch sequencer. Samples the PC, runs a req/ack read
// against instruction memory, hands the word to decode over valid/ready, and
// only lets the PC register advance once decode has taken the instruction.
// Handles redirect flushes, misaligned-PC faults and memory timeouts.
module ifetch_unit #(
  parameter int          TIMEOUT  = 16,             // 2..255
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        dec_ready,
  output logic        fault,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } state_t;

  // Last wait-counter value before the request is declared lost.
  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        pc_en_c;
  logic        bus_err_c;

  // Next-state and combinational outputs for the fetch sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d      = state_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    wcnt_d       = wcnt_q;
    pc_en_c      = 1'b0;
    bus_err_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          pc_en_c = 1'b1;                 // let the redirect target load
        end else if (PC[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          imem_addr_d = PC;
          imem_req_d  = 1'b1;
          wcnt_d      = 8'd0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (flush) begin
          pc_en_c = 1'b1;
          if (imem_ack) begin
            imem_req_d = 1'b0;            // data belongs to the old path
            state_d    = S_IDLE;
          end else begin
            wcnt_d  = 8'd0;               // drain gets its own full budget
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          inst_out_d   = imem_rdata;
          inst_pc_d    = imem_addr_q;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = S_HOLD;
        end else if (wcnt_q == WCNT_LAST) begin
          bus_err_c  = 1'b1;
          imem_req_d = 1'b0;
          state_d    = S_FAULT;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_HOLD: begin
        // A flush outranks decode: the held instruction is simply dropped.
        if (flush || dec_ready) begin
          pc_en_c      = 1'b1;
          inst_valid_d = 1'b0;
          inst_out_d   = NOP_WORD;
          state_d      = S_IDLE;
        end
      end

      S_DRAIN: begin
        // The outstanding read must complete before a new one is issued;
        // flush is ignored here because the PC was already redirected.
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          bus_err_c  = 1'b1;
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_FAULT: begin
        // Terminal until reset.
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (RST) begin
      state_q      <= S_IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0;
      inst_out_q   <= NOP_WORD;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
      wcnt_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      wcnt_q       <= wcnt_d;
    end
  end

  // Combinational strobes are masked while reset is asserted so the PC
  // register never loads and no error is reported during reset.
  assign pc_en      = pc_en_c & ~RST;
  assign bus_err    = bus_err_c & ~RST;
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign fault      = (state_q == S_FAULT);

endmodule
